// File: rtl/attn_pkg.sv
// Shared types and default sizing for the attention-block softmax arbiter.
// Feature macro: SOFTMAX_TIMEOUT_EN (engine watchdog in softmax_row_arbiter).
package attn_pkg;

  localparam int unsigned N_DEF       = 4;
  localparam int unsigned H_DEF       = 4;
  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned FBITS_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 1024;

  localparam int unsigned IDX_W = (H_DEF > 1) ? $clog2(H_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic signed [WIDTH_DEF-1:0] elem_t;

endpackage

// File: rtl/softmax_rr_pick.sv
// Round-robin winner select: rotate req by rr_ptr, take lowest set bit, rotate back.
module softmax_rr_pick #(
  parameter int unsigned H  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [H-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          any_c,
  output logic [IW-1:0] w_c
);

  logic [2*H-1:0] dbl;
  logic [H-1:0]   rot;
  logic [IW-1:0]  idx;
  logic [IW:0]    sum;

  always_comb begin
    dbl = {req, req} >> rr_ptr;
    rot = dbl[H-1:0];
    idx = '0;
    for (int i = int'(H) - 1; i >= 0; i--) begin
      if (rot[i]) idx = IW'(i);
    end
    sum = (IW+1)'(idx) + (IW+1)'(rr_ptr);
    if (sum >= (IW+1)'(H)) sum = sum - (IW+1)'(H);
    any_c = |req;
    w_c   = sum[IW-1:0];
  end

endmodule

// File: rtl/softmax_row_arbiter.sv
// Shares one row-softmax engine between H requesters, round-robin, one row at a time.
// Optional engine watchdog enabled by defining SOFTMAX_TIMEOUT_EN.
module softmax_row_arbiter
  import attn_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned H       = H_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned FBITS   = FBITS_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [H-1:0]                       req,
  input  logic [H-1:0][N-1:0][WIDTH-1:0]     row_in,
  output logic [H-1:0]                       gnt,
  output logic [H-1:0]                       rsp_valid,
  output logic [N-1:0][WIDTH-1:0]            rsp_row,
  output logic                               rsp_err,
  output logic                               busy,
  output logic                               sm_start,
  output logic [N-1:0][WIDTH-1:0]            sm_in,
  input  logic [N-1:0][WIDTH-1:0]            sm_out,
  input  logic                               sm_done
);

  localparam int unsigned IW = (H > 1) ? $clog2(H) : 1;

  // Fixed-point format is carried through untouched; only sanity-check it.
  if (FBITS >= WIDTH) begin : g_bad_fbits
    $error("FBITS must be smaller than WIDTH");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be non-zero");
  end

  arb_state_t                state_q, state_d;
  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]             w_q, w_d;
  logic [H-1:0]              gnt_d, rsp_valid_d;
  logic [N-1:0][WIDTH-1:0]   rsp_row_d, sm_in_d;
  logic                      rsp_err_d, sm_start_d, busy_d;
  logic                      any_c;
  logic [IW-1:0]             w_c;
  logic                      tmo_c;

  softmax_rr_pick #(.H(H), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any_c  (any_c),
    .w_c    (w_c)
  );

`ifdef SOFTMAX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts RUN cycles; held at zero elsewhere so each RUN starts from 0.
  always_comb begin
    cnt_d = '0;
    if (state_q == RUN) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tmo_c = (cnt_q == CW'(TIMEOUT));
`else
  assign tmo_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    w_d         = w_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_row_d   = rsp_row;
    sm_start_d  = sm_start;
    sm_in_d     = sm_in;
    unique case (state_q)
      IDLE: begin
        if (any_c) begin
          gnt_d      = H'(1) << w_c;
          sm_in_d    = row_in[w_c];
          sm_start_d = 1'b1;
          w_d        = w_c;
          state_d    = RUN;
        end
      end
      RUN: begin
        // A completion in the same cycle as the watchdog wins.
        if (sm_done) begin
          rsp_row_d   = sm_out;
          rsp_valid_d = H'(1) << w_q;
          sm_start_d  = 1'b0;
          state_d     = RESP;
        end else if (tmo_c) begin
          rsp_row_d   = '0;
          rsp_valid_d = H'(1) << w_q;
          rsp_err_d   = 1'b1;
          sm_start_d  = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (w_q == IW'(H - 1)) ? '0 : w_q + IW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      w_q       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_row   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      sm_start  <= 1'b0;
      sm_in     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      w_q       <= w_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_row   <= rsp_row_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
      sm_start  <= sm_start_d;
      sm_in     <= sm_in_d;
    end
  end

endmodule

// File: tb/tb_softmax_row_arbiter.sv
// Bench for softmax_row_arbiter: transaction-level model checked every cycle plus directed cases.
module tb_softmax_row_arbiter;
  import attn_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned H     = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned TMO   = 16;
  localparam int unsigned RW    = N * WIDTH;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic [H-1:0]                   req = '0;
  logic [H-1:0][N-1:0][WIDTH-1:0] row_in = '0;
  logic [H-1:0]                   gnt, rsp_valid;
  logic [N-1:0][WIDTH-1:0]        rsp_row, sm_in;
  logic                           rsp_err, busy, sm_start;
  logic [N-1:0][WIDTH-1:0]        sm_out = '0;
  logic                           sm_done = 1'b0;

  always #5 clk = ~clk;

  softmax_row_arbiter #(.N(N), .H(H), .WIDTH(WIDTH), .FBITS(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .row_in(row_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_row(rsp_row), .rsp_err(rsp_err),
    .busy(busy), .sm_start(sm_start), .sm_in(sm_in), .sm_out(sm_out), .sm_done(sm_done)
  );

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] row4(elem_t a, elem_t b, elem_t c, elem_t d);
    return {d, c, b, a};
  endfunction

  // Engine stand-in: done pulse bfm_delay negedges after start is seen; <0 means never.
  int            bfm_delay  = -1;
  logic [RW-1:0] bfm_result = '0;
  initial begin
    int  cnt;
    bit  served;
    cnt = 0;
    served = 1'b0;
    forever begin
      @(negedge clk);
      if (sm_done) begin
        sm_done = 1'b0;
        served  = 1'b1;
      end else if (sm_start && !served) begin
        cnt++;
        if (bfm_delay >= 0 && cnt >= bfm_delay) begin
          sm_done = 1'b1;
          sm_out  = bfm_result;
        end
      end else if (!sm_start) begin
        served = 1'b0;
        cnt    = 0;
      end
    end
  end

  // Reference model: one job at a time, round-robin from m_ptr, outputs one cycle after decisions.
  int            m_phase = 0;  // 0 free, 1 engine running, 2 reply cycle
  int            m_owner = 0;
  int            m_ptr   = 0;
  int            m_cnt   = 0;
  logic [H-1:0]  exp_gnt = '0, exp_rv = '0;
  logic          exp_err = 1'b0, exp_start = 1'b0, exp_busy = 1'b0;
  logic [RW-1:0] exp_row = '0, exp_in = '0;

  always @(posedge clk) begin : model
    int w;
    if (!rst_n) begin
      m_phase <= 0; m_ptr <= 0; m_owner <= 0; m_cnt <= 0;
      exp_gnt <= '0; exp_rv <= '0; exp_err <= 1'b0; exp_start <= 1'b0;
      exp_busy <= 1'b0; exp_row <= '0; exp_in <= '0;
    end else begin
      case (m_phase)
        0: begin
          exp_rv  <= '0;
          exp_err <= 1'b0;
          exp_gnt <= '0;
          w = -1;
          for (int j = 0; j < int'(H); j++)
            if (w < 0 && req[(m_ptr + j) % int'(H)]) w = (m_ptr + j) % int'(H);
          if (w >= 0) begin
            exp_gnt   <= H'(1 << w);
            exp_in    <= row_in[w];
            exp_start <= 1'b1;
            exp_busy  <= 1'b1;
            m_owner   <= w;
            m_cnt     <= 0;
            m_phase   <= 1;
          end
        end
        1: begin
          exp_gnt <= '0;
          if (sm_done) begin
            exp_rv <= H'(1 << m_owner); exp_row <= sm_out; exp_err <= 1'b0;
            exp_start <= 1'b0; m_phase <= 2;
          end
`ifdef SOFTMAX_TIMEOUT_EN
          else if (m_cnt == int'(TMO)) begin
            exp_rv <= H'(1 << m_owner); exp_row <= '0; exp_err <= 1'b1;
            exp_start <= 1'b0; m_phase <= 2;
          end
`endif
          else m_cnt <= m_cnt + 1;
        end
        default: begin
          exp_rv   <= '0;
          exp_err  <= 1'b0;
          exp_busy <= 1'b0;
          m_ptr    <= (m_owner + 1) % int'(H);
          m_phase  <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", gnt, exp_gnt);
      check("rsp_valid", rsp_valid, exp_rv);
      check("rsp_err", rsp_err, exp_err);
      check("busy", busy, exp_busy);
      check("sm_start", sm_start, exp_start);
      check("sm_in", sm_in, exp_in);
      check("rsp_row", rsp_row, exp_row);
    end
  end

  task automatic wait_gnt(output logic [H-1:0] g, output int lat, input int budget);
    g = '0;
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (gnt != '0) begin g = gnt; lat = i; return; end
    end
    vectors++; errors++;
    $display("FAIL wait_gnt: no grant within %0d cycles", budget);
  endtask

  task automatic wait_rsp(output int lat, input int budget);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin lat = i; return; end
    end
    vectors++; errors++;
    $display("FAIL wait_rsp: no response within %0d cycles", budget);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [H-1:0] g;
    int           lat;
    int           order[$];
    int           exp_order[6];
    logic         prev_busy;
    logic [H-1:0] nr;

    // Reset with all requests high.
    req = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_gnt", gnt, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_sm_start", sm_start, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_row", rsp_row, 0);
    end
    rst_n = 1'b1;
    req   = '0;

    // Single request from head 2.
    row_in[2]  = row4(256, 512, 768, 1024);
    bfm_result = row4(8, 24, 64, 160);
    bfm_delay  = 5;
    req        = 4'b0100;
    wait_gnt(g, lat, 10);
    check("t2_gnt", g, 4'b0100);
    check("t2_gnt_latency", lat, 1);
    check("t2_sm_in", sm_in, {32'd1024, 32'd768, 32'd512, 32'd256});
    req = '0;
    wait_rsp(lat, 20);
    check("t2_rsp_latency", lat, 5);
    check("t2_rsp_valid", rsp_valid, 4'b0100);
    check("t2_rsp_row", rsp_row, {32'd160, 32'd64, 32'd24, 32'd8});
    check("t2_rsp_err", rsp_err, 0);

    // Pointer now sits at 3: serve head 3, then 0 wins after wrap.
    bfm_delay  = 2;
    bfm_result = row4(-1, 2, -3, 4);
    row_in[3]  = row4(11, 12, 13, 14);
    row_in[0]  = row4(1, 2, 3, 4);
    req = 4'b1000;
    wait_gnt(g, lat, 10);
    check("t4_first_gnt", g, 4'b1000);
    req = '0;
    wait_rsp(lat, 20);
    req = 4'b1001;
    wait_gnt(g, lat, 10);
    check("t4_wrap_gnt", g, 4'b0001);
    req = '0;
    wait_rsp(lat, 20);

    // Reset mid-run drops the row without a response.
    bfm_delay = -1;
    row_in[1] = row4(5, 6, 7, 8);
    req = 4'b0010;
    wait_gnt(g, lat, 10);
    check("t6_gnt", g, 4'b0010);
    req = '0;
    repeat (2) @(negedge clk);
    do_reset(1);
    check("t6_busy", busy, 0);
    check("t6_sm_start", sm_start, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_rsp", rsp_valid, 0);
    end
    bfm_delay = 2;
    req = 4'b1111;
    wait_gnt(g, lat, 10);
    check("t6_restart_gnt", g, 4'b0001);
    req = '0;
    wait_rsp(lat, 20);

    // All heads requesting, each re-raising after its reply.
    do_reset(2);
    bfm_delay = 3;
    exp_order = '{0, 1, 2, 3, 0, 1};
    req = '1;
    prev_busy = 1'b0;
    for (int c = 0; c < 400 && order.size() < 6; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        check("t3_gnt_while_busy", prev_busy, 0);
        for (int i = 0; i < int'(H); i++) if (gnt[i]) order.push_back(i);
      end
      prev_busy = busy;
      nr = req;
      for (int i = 0; i < int'(H); i++) nr[i] = !rsp_valid[i];
      req = nr;
    end
    req = '0;
    check("t3_grant_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      check($sformatf("t3_order%0d", i), order[i], exp_order[i]);
    for (int c = 0; c < 50 && busy; c++) @(negedge clk);
    check("t3_idle", busy, 0);

    // Engine never finishes.
    bfm_delay = -1;
    req = 4'b0001;
    wait_gnt(g, lat, 10);
    check("t5_gnt", g, 4'b0001);
    req = '0;
`ifdef SOFTMAX_TIMEOUT_EN
    wait_rsp(lat, 100);
    check("t5_tmo_latency", lat, 17);
    check("t5_tmo_valid", rsp_valid, 4'b0001);
    check("t5_tmo_err", rsp_err, 1);
    check("t5_tmo_row", rsp_row, 0);
    @(negedge clk);
`else
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("t5_busy_hold", busy, 1);
    end
    do_reset(1);
`endif
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
